// File: rtl/udma_filter_pkg.sv
// udma_filter_pkg: datasize encodings and read-data alignment shared by the uDMA responder
package udma_filter_pkg;

   typedef enum logic [1:0] {
      DSIZE_BYTE = 2'b00,
      DSIZE_HALF = 2'b01,
      DSIZE_WORD = 2'b10,
      DSIZE_RSVD = 2'b11
   } dsize_e;

   // Picks the addressed lane out of a memory word and zero-extends it; the reserved size reads as a word
   function automatic logic [31:0] align_rdata(input logic [31:0] rdata, input logic [1:0] lsb, input logic [1:0] dsize);
      return (dsize == DSIZE_BYTE) ? ((rdata >> {lsb, 3'b000}) & 32'h0000_00FF) :
             (dsize == DSIZE_HALF) ? ((rdata >> {lsb[1], 4'b0000}) & 32'h0000_FFFF) :
                                     rdata;
   endfunction

endpackage

// File: rtl/udma_tx_responder_if.sv
// udma_tx_responder_if: initiator read channel plus the single-cycle memory read port
interface udma_tx_responder_if #(
   parameter int DATA_WIDTH     = 32,
   parameter int L2_AWIDTH_NOAL = 15
);
   logic                        tx_req_i;
   logic [L2_AWIDTH_NOAL-1:0]   tx_addr_i;
   logic [1:0]                  tx_datasize_i;
   logic                        tx_gnt_o;
   logic                        tx_valid_o;
   logic [DATA_WIDTH-1:0]       tx_data_o;
   logic                        tx_ready_i;
   logic                        mem_re_o;
   logic [L2_AWIDTH_NOAL-3:0]   mem_addr_o;
   logic [31:0]                 mem_rdata_i;
   logic                        busy_o;

   modport slave (
      input  tx_req_i, tx_addr_i, tx_datasize_i, tx_ready_i, mem_rdata_i,
      output tx_gnt_o, tx_valid_o, tx_data_o, mem_re_o, mem_addr_o, busy_o
   );

   modport master (
      output tx_req_i, tx_addr_i, tx_datasize_i, tx_ready_i, mem_rdata_i,
      input  tx_gnt_o, tx_valid_o, tx_data_o, mem_re_o, mem_addr_o, busy_o
   );
endinterface

// File: rtl/udma_resp_fifo.sv
// udma_resp_fifo: response buffer with no bypass; reads as zero while empty
module udma_resp_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             resetn_i,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);
   localparam int PW = $clog2(DEPTH);

   logic [PW:0]      r_wptr;
   logic [PW:0]      r_rptr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = r_wptr == r_rptr;
   assign o_full    = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_rdata   = o_empty ? '0 : r_mem[r_rptr[PW-1:0]];

   // Pointers carry a wrap bit so full and empty are distinguishable
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + 1'b1;
         if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   // Storage needs no reset: an entry is only ever read after it was written
   always_ff @(posedge clk_i) begin
      if (w_do_push) r_mem[r_wptr[PW-1:0]] <= i_wdata;
   end
endmodule

// File: rtl/udma_tx_responder.sv
// udma_tx_responder: credit-limited read responder with a two-cycle grant-to-valid path
module udma_tx_responder
   import udma_filter_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int L2_AWIDTH_NOAL = 15,
   parameter int DEPTH          = 4
) (
   input logic                 clk_i,
   input logic                 resetn_i,
   udma_tx_responder_if.slave  bus
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [CW-1:0]         r_count;
   logic                  r_pend;
   logic [1:0]            r_lsb;
   logic [1:0]            r_dsize;
   logic                  w_gnt;
   logic                  w_pop;
   logic                  w_empty;
   logic                  w_full;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic [DATA_WIDTH-1:0] w_rdata;

   // Credits come from the registered count only, so a pop frees its slot one cycle later
   assign w_gnt   = resetn_i && bus.tx_req_i && (r_count < CW'(DEPTH));
   assign w_pop   = !w_empty && bus.tx_ready_i;
   assign w_wdata = align_rdata(bus.mem_rdata_i, r_lsb, r_dsize);

   assign bus.tx_gnt_o   = w_gnt;
   assign bus.mem_re_o   = w_gnt;
   assign bus.mem_addr_o = bus.tx_addr_i[L2_AWIDTH_NOAL-1:2];
   assign bus.tx_valid_o = !w_empty;
   assign bus.tx_data_o  = w_rdata;
   assign bus.busy_o     = r_count != '0;

   // Outstanding responses: reads in flight plus entries waiting in the buffer
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) r_count <= '0;
      else           r_count <= (w_gnt && !w_pop) ? r_count + 1'b1 :
                                (!w_gnt && w_pop) ? r_count - 1'b1 : r_count;
   end

   // Side pipeline keeps lane select and size aligned with the memory data returning next cycle
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         r_pend  <= 1'b0;
         r_lsb   <= '0;
         r_dsize <= '0;
      end else begin
         r_pend <= w_gnt;
         if (w_gnt) begin
            r_lsb   <= bus.tx_addr_i[1:0];
            r_dsize <= bus.tx_datasize_i;
         end
      end
   end

   udma_resp_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i    (clk_i),
      .resetn_i (resetn_i),
      .i_push   (r_pend),
      .i_wdata  (w_wdata),
      .i_pop    (w_pop),
      .o_rdata  (w_rdata),
      .o_full   (w_full),
      .o_empty  (w_empty)
   );

   logic w_unused;
   assign w_unused = w_full;
endmodule

// File: doc/udma_tx_responder.md
UDMA_TX_RESPONDER -- requirements
Module: udma_tx_responder

Interface
REQ-001 DATA_WIDTH, 32, response data width; only 32 is supported.
REQ-002 L2_AWIDTH_NOAL, 15, byte address width of the request.
REQ-003 DEPTH, 4, maximum outstanding responses (read in flight plus buffered); power of two, at least 2.
REQ-004 clk_i  in  1  single clock; all logic on the rising edge.
REQ-005 resetn_i  in  1  asynchronous active-low reset.
REQ-006 tx_req_i  in  1  initiator read request.
REQ-007 tx_addr_i  in  L2_AWIDTH_NOAL  request byte address.
REQ-008 tx_datasize_i  in  2  access size: 00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-009 tx_gnt_o  out  1  request accepted this cycle.
REQ-010 tx_valid_o  out  1  response data valid.
REQ-011 tx_data_o  out  DATA_WIDTH  aligned, zero-extended response data.
REQ-012 tx_ready_i  in  1  initiator accepts the response.
REQ-013 mem_re_o  out  1  memory read strobe.
REQ-014 mem_addr_o  out  L2_AWIDTH_NOAL-2  word address, equal to tx_addr_i[L2_AWIDTH_NOAL-1:2].
REQ-015 mem_rdata_i  in  32  memory read data, valid exactly 1 cycle after mem_re_o.
REQ-016 busy_o  out  1  high while the outstanding count is nonzero.

Function
REQ-017 The block SHALL keep an outstanding count: incremented on grant, decremented on response pop (tx_valid_o && tx_ready_i); simultaneous grant and pop leave it unchanged.
REQ-018 tx_gnt_o SHALL equal tx_req_i && (count < DEPTH), using the registered count only; a same-cycle pop does not free a credit.
REQ-019 mem_re_o SHALL equal tx_gnt_o, and mem_addr_o SHALL be driven combinationally from tx_addr_i.
REQ-020 On grant, addr[1:0] and datasize SHALL be registered into a 1-stage side pipeline aligned with mem_rdata_i.
REQ-021 Alignment:
- byte: data = zero-extended mem_rdata_i[8*a+7:8*a], where a = addr[1:0].
- halfword: data = zero-extended mem_rdata_i[16*addr[1]+15:16*addr[1]]; addr[0] is ignored.
- word: data = full mem_rdata_i.
REQ-022 Aligned data SHALL be pushed into the response FIFO at the end of cycle N+1 for a grant in cycle N; tx_valid_o SHALL rise in cycle N+2 (grant-to-valid latency is 2).
REQ-023 The FIFO SHALL have no bypass path; a push into an empty FIFO is visible on tx_valid_o the following cycle.
REQ-024 tx_valid_o/tx_data_o SHALL present the FIFO head and SHALL stay stable while tx_valid_o && !tx_ready_i.
REQ-025 Responses SHALL return in grant order.
REQ-026 With tx_req_i and tx_ready_i held high, throughput SHALL be 1 grant and 1 response per cycle.
REQ-027 The FIFO SHALL never overflow by construction: the credit limit guarantees occupancy ≤ DEPTH. The FIFO SHALL drive no pop when empty.
REQ-028 tx_ready_i without tx_valid_o SHALL have no effect.
REQ-029 busy_o SHALL be high iff the registered count is nonzero.

Reset
REQ-030 Asserting resetn_i low SHALL immediately clear the count, FIFO pointers, side pipeline and any pending push. This drives tx_gnt_o, mem_re_o, tx_valid_o and busy_o low, and tx_data_o to 0.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight and buffered responses. The first grant after deassertion SHALL behave as from idle.

Structure
REQ-032 The shared package udma_filter_pkg SHALL hold the datasize encodings DSIZE_BYTE, DSIZE_HALF and DSIZE_WORD, plus the alignment function used by REQ-021.
REQ-033 The response buffer SHALL be a separate sub-module, udma_resp_fifo, parameterised by width and DEPTH, with push/pop/full/empty ports.

Verification
REQ-034 Word read: memory word 5 = 0xDEADBEEF; request addr 0x14, size 10, ready high -> gnt in cycle 0, mem_addr_o = 5, tx_valid_o in cycle 2 with data 0xDEADBEEF.
REQ-035 Sub-word reads on the same word:
- byte addr 0x17 -> 0x000000DE.
- halfword addr 0x16 -> 0x0000DEAD.
- halfword addr 0x15 -> 0x0000BEEF.
REQ-036 Backpressure: ready low, req held high -> exactly 4 grants, then gnt low. Raise ready -> 4 responses in order, and gnt resumes the cycle after the first pop.
REQ-037 Streaming: 16 back-to-back word requests with ready high -> 16 consecutive grants and 16 consecutive valid cycles starting 2 cycles later, data in address order.
REQ-038 Reset mid-burst: after 3 grants with ready low, pulse resetn_i -> tx_valid_o low immediately, busy_o low, and the next request returns its own data 2 cycles after grant.
